// File: rtl/wb_uart_periph_if.sv
// Wishbone classic slave bundle for the UART peripheral.
// Signal names carry the slave's point of view (i_ = into the peripheral).
interface wb_uart_periph_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic [31:0] o_wb_data;
  logic        o_wb_stall;
  logic        o_wb_ack;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_data, o_wb_stall, o_wb_ack
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_data, o_wb_stall, o_wb_ack
  );
endinterface

// File: rtl/wb_uart_periph.sv
// Wishbone-attached 8N1 UART with TX/RX FIFOs, sticky error flags and a level interrupt.
// Registers: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (word addressed by addr[3:2]).
module wb_uart_periph #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_uart_periph_if.slave  io_wb,
  input  logic             i_uart_rx,
  output logic             o_uart_tx,
  output logic             o_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Bus decode
  logic        r_ack, r_rx_ie, r_tx_ie, r_ovr, r_frm, r_irq;
  logic [31:0] r_rdata, w_rdata;
  logic        w_req, w_rd, w_wr, w_sel0, w_unused;
  logic [1:0]  w_addr;

  assign w_req  = io_wb.i_wb_cyc & io_wb.i_wb_stb & ~r_ack;
  assign w_rd   = w_req & ~io_wb.i_wb_we;
  assign w_wr   = w_req & io_wb.i_wb_we;
  assign w_addr = io_wb.i_wb_addr[3:2];
  assign w_sel0 = io_wb.i_wb_sel[0];
  assign w_unused = ^{io_wb.i_wb_addr[31:4], io_wb.i_wb_addr[1:0], io_wb.i_wb_data[31:8],
                      io_wb.i_wb_sel[3:1]};

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp, w_rx_diff;
  logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_idle;
  logic [7:0]    w_rx_cnt;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_diff  = r_rx_wp - r_rx_rp;
  assign w_rx_cnt   = 8'(w_rx_diff);
  assign w_tx_push  = w_wr && (w_addr == 2'd0) && w_sel0 && !w_tx_full;
  assign w_rx_pop   = w_rd && (w_addr == 2'd0) && !w_rx_empty;

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= io_wb.i_wb_data[7:0];
  end

  // ---------------- TX ----------------
  uart_st_e      r_tx_st, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          w_tx_cnt_done;

  assign w_tx_cnt_done = (r_tx_cnt == BitLast);
  assign w_tx_idle     = w_tx_empty && (r_tx_st == StIdle);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tx_st <= StIdle;
    else       r_tx_st <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_st;
    unique case (r_tx_st)
      StIdle:  if (!w_tx_empty) w_tx_next = StStart;
      StStart: if (w_tx_cnt_done) w_tx_next = StData;
      StData:  if (w_tx_cnt_done && r_tx_bit == 3'd7) w_tx_next = StStop;
      StStop:  if (w_tx_cnt_done) w_tx_next = w_tx_empty ? StIdle : StStart;
      default: w_tx_next = StIdle;
    endcase
  end

  // Line is a decode of reset registers so reset drives it high without waiting for a clock
  always_comb begin
    o_uart_tx = 1'b1;
    w_tx_pop  = 1'b0;
    unique case (r_tx_st)
      StIdle:  w_tx_pop  = !w_tx_empty;
      StStart: o_uart_tx = 1'b0;
      StData:  o_uart_tx = r_tx_shift[0];
      StStop:  w_tx_pop  = w_tx_cnt_done && !w_tx_empty;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= 8'hFF;
    end else if (w_tx_pop) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= r_tx_mem[r_tx_rp[AW-1:0]];
    end else if (r_tx_st != StIdle) begin
      if (w_tx_cnt_done) begin
        r_tx_cnt <= '0;
        if (r_tx_st == StData) begin
          r_tx_shift <= {1'b1, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  uart_st_e      r_rx_st, w_rx_next;
  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx_fall, w_rx_sample, w_rx_bit_done, w_rx_ovr_set, w_rx_frm_set;

  assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
  assign w_rx_bit_done = (r_rx_cnt == BitLast);
  assign w_rx_sample   = ((r_rx_st == StStart) && (r_rx_cnt == HalfLast)) ||
                         (((r_rx_st == StData) || (r_rx_st == StStop)) && w_rx_bit_done);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rx_st <= StIdle;
    else       r_rx_st <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_st;
    unique case (r_rx_st)
      StIdle:  if (w_rx_fall) w_rx_next = StStart;
      StStart: if (r_rx_cnt == HalfLast) w_rx_next = r_rx_s2 ? StIdle : StData;
      StData:  if (w_rx_bit_done && r_rx_bit == 3'd7) w_rx_next = StStop;
      StStop:  if (w_rx_bit_done) w_rx_next = StIdle;
      default: w_rx_next = StIdle;
    endcase
  end

  always_comb begin
    w_rx_push    = 1'b0;
    w_rx_ovr_set = 1'b0;
    w_rx_frm_set = 1'b0;
    if (r_rx_st == StStop && w_rx_bit_done) begin
      w_rx_push    = r_rx_s2 && !w_rx_full;
      w_rx_ovr_set = r_rx_s2 && w_rx_full;
      w_rx_frm_set = !r_rx_s2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_rx_cnt <= (r_rx_st == StIdle || w_rx_sample) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_st == StStart) r_rx_bit <= '0;
      if (r_rx_st == StData && w_rx_bit_done) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift;
  end

  // ---------------- Pointers, CTRL, flags, bus response ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
      r_rx_wp <= '0;
      r_rx_rp <= '0;
      r_rx_ie <= 1'b0;
      r_tx_ie <= 1'b0;
      r_ovr   <= 1'b0;
      r_frm   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_wr && w_addr == 2'd2 && w_sel0) begin
        r_rx_ie <= io_wb.i_wb_data[0];
        r_tx_ie <= io_wb.i_wb_data[1];
        if (io_wb.i_wb_data[3]) r_ovr <= 1'b0;
        if (io_wb.i_wb_data[4]) r_frm <= 1'b0;
      end
      // A new error in the same cycle as a clear wins
      if (w_rx_ovr_set) r_ovr <= 1'b1;
      if (w_rx_frm_set) r_frm <= 1'b1;
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rdata : '0;
      r_irq   <= (r_rx_ie & ~w_rx_empty) | (r_tx_ie & w_tx_idle);
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_addr)
      2'd0: w_rdata = w_rx_empty ? 32'h8000_0000 : {24'b0, r_rx_mem[r_rx_rp[AW-1:0]]};
      2'd1: w_rdata = {19'b0, w_rx_cnt, r_frm, r_ovr, w_tx_idle, w_tx_full, ~w_rx_empty};
      2'd2: w_rdata = {30'b0, r_tx_ie, r_rx_ie};
      default: w_rdata = '0;
    endcase
  end

  assign io_wb.o_wb_stall = 1'b0;
  assign io_wb.o_wb_ack   = r_ack;
  assign io_wb.o_wb_data  = r_rdata;
  assign o_irq            = r_irq;

endmodule

// File: tb/tb_wb_uart_periph.sv
// Self-checking bench for wb_uart_periph: scoreboard queues of expected read data,
// expected serial bits and expected bytes, drained as the DUT responds.
module tb_wb_uart_periph;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic uart_rx;
  logic uart_tx;
  logic irq;

  wb_uart_periph_if bus ();

  wb_uart_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .io_wb     (bus),
    .i_uart_rx (uart_rx),
    .o_uart_tx (uart_tx),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic        bit_q[$];

  // Called and returns at posedge+1
  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, output logic [31:0] rdata);
    int n;
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    bus.i_wb_sel  = sel;
    rdata = '0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_wb_ack && n < 8);
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    if (!bus.o_wb_ack) begin
      n_checks++; n_fail++;
      $display("FAIL wb_ack_timeout addr=%h got ack=0 expected ack=1", addr);
    end else begin
      rdata = bus.o_wb_data;
    end
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] d;
    wb_xfer(1'b1, addr, data, sel, d);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    wb_xfer(1'b0, addr, 32'h0, 4'hF, data);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] got, e;
    logic [31:0] addrs [4];
    addrs = '{32'h4, 32'h8, 32'hC, 32'h0};
    n_checks++;
    if (uart_tx !== 1'b1 || irq !== 1'b0 || bus.o_wb_ack !== 1'b0 || bus.o_wb_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got tx=%b irq=%b ack=%b data=%h expected 1 0 0 0",
               uart_tx, irq, bus.o_wb_ack, bus.o_wb_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      wb_read(addrs[i], got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got %h expected %h", addrs[i], got, e);
      end
    end
  endtask

  task automatic test_tx;
    logic [31:0] got, e;
    logic [7:0] b;
    int n;
    b = 8'h55;
    wb_write(32'h0, {24'h0, b}, 4'h1);
    for (int i = 0; i < CPB; i++) bit_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) for (int i = 0; i < CPB; i++) bit_q.push_back(b[k]);
    for (int i = 0; i < CPB; i++) bit_q.push_back(1'b1);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL tx_start_timeout got tx=%b expected 0", uart_tx);
      bit_q.delete();
    end
    n = 0;
    while (bit_q.size() > 0) begin
      e = {31'b0, bit_q.pop_front()};
      n_checks++;
      if (uart_tx !== e[0]) begin
        n_fail++;
        $display("FAIL tx_bit sample=%0d got %b expected %b", n, uart_tx, e[0]);
      end
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL tx_status_after got %h expected %h", got, e);
    end
  endtask

  task automatic test_rx;
    logic [31:0] got, e;
    uart_send(8'hA3, 1'b1);
    byte_q.push_back(8'hA3);
    exp_q.push_back(32'h0000_0025);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rx_status got %h expected %h", got, e);
    end
    exp_q.push_back({24'h0, byte_q.pop_front()});
    exp_q.push_back(32'h8000_0000);
    for (int i = 0; i < 2; i++) begin
      wb_read(32'h0, got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rx_data read=%0d got %h expected %h", i, got, e);
      end
    end
  endtask

  task automatic test_overrun;
    logic [31:0] got, e;
    for (int i = 1; i <= 5; i++) begin
      uart_send(8'(i), 1'b1);
      if (i <= DEPTH) byte_q.push_back(8'(i));
    end
    // 4 entries, overrun, tx idle, not empty
    exp_q.push_back(32'h0000_008D);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL ovr_status got %h expected %h", got, e);
    end
    while (byte_q.size() > 0) begin
      exp_q.push_back({24'h0, byte_q.pop_front()});
      wb_read(32'h0, got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ovr_data got %h expected %h", got, e);
      end
    end
    wb_write(32'h8, 32'h08, 4'h1);
    exp_q.push_back(32'h0000_0004);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL ovr_clear got %h expected %h", got, e);
    end
  endtask

  task automatic test_frame_and_glitch;
    logic [31:0] got, e;
    uart_send(8'h3C, 1'b0);
    exp_q.push_back(32'h0000_0014);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL frame_status got %h expected %h", got, e);
    end
    wb_write(32'h8, 32'h10, 4'h1);
    uart_rx = 1'b0;
    repeat (2) @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (6 * CPB) @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL glitch_status got %h expected %h", got, e);
    end
  endtask

  task automatic test_sel_reserved;
    logic [31:0] got, e;
    wb_write(32'h0, 32'h0000_00AA, 4'b1110);
    wb_write(32'hC, 32'hFFFF_FFFF, 4'hF);
    repeat (3) @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL sel0_ignored got %h expected %h", got, e);
    end
    wb_read(32'hC, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reserved_read got %h expected %h", got, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, e;
    int lows;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i < 5) byte_q.push_back(8'h10 + 8'(i));
          wb_write(32'h0, 32'h10 + 32'(i), 4'h1);
        end
        exp_q.push_back(32'h0000_0002);
        wb_read(32'h4, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL tx_full_status got %h expected %h", got, e);
        end
      end
      begin
        logic [7:0] rb, eb;
        int n;
        for (int k = 0; k < 5; k++) begin
          n = 0;
          while (uart_tx !== 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
          end
          repeat (CPB / 2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rb[i] = uart_tx;
          end
          repeat (CPB) @(negedge clk);
          eb = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hXX;
          n_checks++;
          if (rb !== eb || uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_byte=%0d got %h stop=%b expected %h stop=1", k, rb, uart_tx, eb);
          end
        end
      end
    join
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL tx_drop_on_full got %0d low samples expected 0", lows);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_irq;
    logic [31:0] got;
    wb_write(32'h8, 32'h1, 4'h1);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle got %b expected 0", irq);
    end
    uart_send(8'h7E, 1'b1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx got %b expected 1", irq);
    end
    wb_read(32'h0, got);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b0 || got !== 32'h7E) begin
      n_fail++;
      $display("FAIL irq_pop got irq=%b data=%h expected irq=0 data=0000007e", irq, got);
    end
    wb_write(32'h8, 32'h2, 4'h1);
    @(posedge clk); #1;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_tx_idle got %b expected 1", irq);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] got, e;
    int n;
    uart_send(8'h5A, 1'b1);
    wb_write(32'h8, 32'h1, 4'h1);
    wb_write(32'h0, 32'h00, 4'h1);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Sample 17 from the start edge sits inside data bit 3
    repeat (17) @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_bit3_low got %b expected 0", uart_tx);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1 || irq !== 1'b0 || bus.o_wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async got tx=%b irq=%b ack=%b expected 1 0 0",
               uart_tx, irq, bus.o_wb_ack);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0);
    wb_read(32'h4, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL post_reset_status got %h expected %h", got, e);
    end
    wb_read(32'h8, got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL post_reset_ctrl got %h expected %h", got, e);
    end
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) n++;
    end
    n_checks++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL post_reset_tx_quiet got %0d low samples expected 0", n);
    end
  endtask

  initial begin
    rst           = 1'b1;
    uart_rx       = 1'b1;
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    bus.i_wb_sel  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset;
    test_tx;
    test_rx;
    test_overrun;
    test_frame_and_glitch;
    test_sel_reserved;
    test_back_to_back;
    test_irq;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
